set_time_editor: RTL and testbench
==================================

SET_TIME_EDITOR -- requirements
Module: set_time_editor

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-002 SHALL have port: mode  in  4  clock mode; 0 = run, SET_MODE (package constant, 4'd1) = edit.
REQ-003 SHALL have ports: btn_left, btn_right, btn_up, btn_down  in  1 each  single-cycle debounced button pulses.
REQ-004 SHALL have ports: load_value  in  84  current time string, 21 nibbles, nibble i at [4i+3:4i]; commit_ready  in  1  consumer accepts commit.
REQ-005 SHALL have ports: tmp1  out  84  edit buffer for the display window selector; count  out  5  cursor index 0..20.
REQ-006 SHALL have ports: commit_valid  out  1  edited value available; commit_value  out  84  edited value, equal to tmp1.

Function
REQ-007 SHALL implement FSM states IDLE, LOAD, EDIT, COMMIT.
REQ-008 IDLE: when mode==SET_MODE, SHALL go to LOAD; otherwise SHALL stay in IDLE.
REQ-009 LOAD: tmp1 SHALL take load_value in one cycle, with separators forced to 4'hF, digits above FIELD_MAX clamped to FIELD_MAX, and count set to 20; next state SHALL be EDIT.
REQ-010 EDIT: mode leaving SET_MODE SHALL go to COMMIT on the next edge; buttons in that cycle SHALL be ignored.
REQ-011 Field table (package FIELD_MAX[20:0]) SHALL be: 20-17 = 9; 16 = F; 15 = 1; 14 = 9; 13 = F; 12 = 3; 11 = 9; 10 = F; 9 = 2; 8 = 9; 7 = F; 6 = 5; 5 = 9; 4 = F; 3 = 5; 2 = 9; 1 = F; 0 = 6. F marks a separator.
REQ-012 btn_left SHALL move count to the nearest higher non-separator index; at 20 count SHALL hold (no wrap).
REQ-013 btn_right SHALL move count to the nearest lower non-separator index; at 0 count SHALL hold.
REQ-014 btn_up SHALL increment nibble[count], wrapping from FIELD_MAX to 0.
REQ-015 btn_down SHALL decrement nibble[count], wrapping from 0 to FIELD_MAX.
REQ-016 Each button effect SHALL be visible on tmp1/count one cycle after the pulse.
REQ-017 Simultaneous buttons SHALL resolve by priority up > down > left > right; exactly one action SHALL occur per cycle.
REQ-018 count SHALL never rest on a separator index.
REQ-019 Nibbles other than nibble[count] SHALL be unchanged by up/down.
REQ-020 COMMIT: commit_valid SHALL assert and hold, with commit_value stable, until commit_ready is sampled high; then FSM SHALL go to IDLE and commit_valid SHALL deassert on the next cycle.
REQ-021 If mode returns to SET_MODE during COMMIT, the pending commit SHALL still complete before re-entering LOAD.
REQ-022 In IDLE, tmp1 SHALL track load_value each cycle with the same sanitising as LOAD; count SHALL hold 20.

Reset
REQ-023 On reset: state = IDLE, count = 20, tmp1 = all zeros with separators 4'hF, commit_valid = 0.
REQ-024 Reset SHALL abort any edit or pending commit without asserting commit_valid afterwards.

Structure
REQ-025 Package set_time_pkg SHALL hold SET_MODE, NUM_CHARS = 21, SEP_CODE = 4'hF, FIELD_MAX table, and the state enum.
REQ-026 A sub-module nibble_wrap_counter (value, max, up, down -> next) SHALL implement the REQ-014/015 arithmetic.
REQ-027 count SHALL be 5 bits unsigned; arithmetic SHALL never produce an index above 20.

Verification
REQ-028 Reset, then mode = 1 with load_value nibble[20..17] = 2,0,2,4 -> after 2 cycles tmp1[83:68] = 16'h2024, count = 20.
REQ-029 In EDIT at count = 20, three btn_right pulses -> count sequence 19, 18, 17; a fourth -> 15 (separator 16 skipped).
REQ-030 Cursor at 15 (max 1) holding 1, btn_up -> 0; btn_down from 0 -> 1; nibble 14 unchanged.
REQ-031 btn_up and btn_left in the same cycle at count = 8 -> nibble 8 increments and count stays 8.
REQ-032 mode -> 0 with commit_ready low for 3 cycles -> commit_valid held 3 cycles with stable value; commit_ready = 1 -> IDLE, commit_valid = 0 next cycle.
REQ-033 Reset asserted mid-EDIT after edits -> count = 20, commit_valid never asserts, state IDLE.

Source files
------------

// File: rtl/set_time_editor_pkg.sv
// Shared constants, field table and FSM encoding for the set-time editor.
// The edit buffer holds 21 nibbles; nibble i sits at bits [4i+3:4i].
package set_time_pkg;

   localparam logic [3:0] SET_MODE  = 4'd1;
   localparam int         NUM_CHARS = 21;
   localparam int         BUF_W     = 4 * NUM_CHARS;
   localparam logic [3:0] SEP_CODE  = 4'hF;
   localparam logic [4:0] LAST_IDX  = 5'd20;

   // Per-position maximum digit, index 20 first; SEP_CODE marks a separator.
   localparam logic [NUM_CHARS-1:0][3:0] FIELD_MAX = {
      4'h9, 4'h9, 4'h9, 4'h9, 4'hF, 4'h1, 4'h9, 4'hF, 4'h3, 4'h9, 4'hF,
      4'h2, 4'h9, 4'hF, 4'h5, 4'h9, 4'hF, 4'h5, 4'h9, 4'hF, 4'h6
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EDIT,
      ST_COMMIT
   } state_e;

   function automatic logic is_sep(input logic [4:0] idx);
      return FIELD_MAX[idx] == SEP_CODE;
   endfunction

   // Force separators and clamp out-of-range digits to their field maximum.
   function automatic logic [BUF_W-1:0] sanitize(input logic [BUF_W-1:0] raw);
      logic [BUF_W-1:0] res;
      res = '0;
      for (int i = 0; i < NUM_CHARS; i++) begin
         if (FIELD_MAX[i] == SEP_CODE)
            res[4*i +: 4] = SEP_CODE;
         else if (raw[4*i +: 4] > FIELD_MAX[i])
            res[4*i +: 4] = FIELD_MAX[i];
         else
            res[4*i +: 4] = raw[4*i +: 4];
      end
      return res;
   endfunction

   localparam logic [BUF_W-1:0] RESET_BUF = sanitize('0);

endpackage

// File: rtl/set_time_editor_nibble_wrap_counter.sv
// Single-digit up/down counter that wraps between 0 and a per-field maximum.
// Up wins over down when both are requested.
module nibble_wrap_counter (
   input  logic [3:0] value_i,
   input  logic [3:0] max_i,
   input  logic       up_i,
   input  logic       down_i,
   output logic [3:0] next_o
);

   // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      next_o = value_i;
      if (up_i)
         next_o = (value_i >= max_i) ? 4'd0 : value_i + 4'd1;
      else if (down_i)
         next_o = (value_i == 4'd0 || value_i > max_i) ? max_i : value_i - 4'd1;
   end

endmodule

// File: rtl/set_time_editor.sv
// Time-string editor: loads the current time, lets the user move a cursor and
// step digits, then hands the edited string to a consumer with valid/ready.
module set_time_editor
   import set_time_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       mode,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic [BUF_W-1:0] load_value,
   input  logic             commit_ready,
   output logic [BUF_W-1:0] tmp1,
   output logic [4:0]       count,
   output logic             commit_valid,
   output logic [BUF_W-1:0] commit_value
);

   state_e           state_q, state_d;
   logic [BUF_W-1:0] tmp1_q, tmp1_d;
   logic [4:0]       count_q, count_d;
   logic [6:0]       nib_lsb;
   logic [3:0]       cur_nib, cur_max, nib_next;
   logic [4:0]       left_idx, right_idx;
   logic             edit_active;

   assign nib_lsb     = {count_q, 2'b00};
   assign cur_nib     = tmp1_q[nib_lsb +: 4];
   assign cur_max     = FIELD_MAX[count_q];
   assign edit_active = (state_q == ST_EDIT) && (mode == SET_MODE);

   nibble_wrap_counter u_wrap (
      .value_i (cur_nib),
      .max_i   (cur_max),
      .up_i    (btn_up),
      .down_i  (btn_down),
      .next_o  (nib_next)
   );

   // Separators are isolated, so one extra step always lands on a digit.
   always_comb begin
      left_idx = count_q;
      if (count_q < LAST_IDX) begin
         left_idx = count_q + 5'd1;
         if (is_sep(left_idx))
            left_idx = count_q + 5'd2;
      end
      right_idx = count_q;
      if (count_q != 5'd0) begin
         right_idx = count_q - 5'd1;
         if (is_sep(right_idx))
            right_idx = count_q - 5'd2;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (mode == SET_MODE) state_d = ST_LOAD;
         ST_LOAD:   state_d = ST_EDIT;
         ST_EDIT:   if (mode != SET_MODE) state_d = ST_COMMIT;
         ST_COMMIT: if (commit_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath next state; one button action per cycle, up > down > left > right.
   always_comb begin
      tmp1_d  = tmp1_q;
      count_d = count_q;
      if (state_q == ST_IDLE || state_q == ST_LOAD) begin
         tmp1_d  = sanitize(load_value);
         count_d = LAST_IDX;
      end else if (edit_active) begin
         if (btn_up || btn_down)
            tmp1_d[nib_lsb +: 4] = nib_next;
         else if (btn_left)
            count_d = left_idx;
         else if (btn_right)
            count_d = right_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmp1_q  <= RESET_BUF;
         count_q <= LAST_IDX;
      end else begin
         tmp1_q  <= tmp1_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      commit_valid = (state_q == ST_COMMIT);
      commit_value = tmp1_q;
      tmp1         = tmp1_q;
      count        = count_q;
   end

endmodule

// File: tb/tb_set_time_editor.sv
// Self-checking bench for set_time_editor: a cursor/digit vector table plus
// hand-written load, commit handshake and mid-edit reset sequences.
module tb_set_time_editor;
   import set_time_pkg::*;

   localparam logic [83:0] RAW_TIME  = 84'h2_0_2_4_0_1_2_0_9_1_0_2_3_0_5_9_0_5_9_0_7;
   localparam logic [83:0] SAN_TIME  = 84'h2024F12F31F23F59F59F6;
   localparam logic [83:0] EDIT_TIME = 84'h2024F12F31F23F59F59F0;
   localparam logic [83:0] RST_BUF   = 84'h0000F00F00F00F00F00F0;
   localparam logic [3:0]  B_NONE = 4'b0000, B_R = 4'b0001, B_L = 4'b0010,
                           B_D = 4'b0100, B_U = 4'b1000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  mode = 4'd0;
   logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [83:0] load_value = '0;
   logic        commit_ready = 1'b0;
   logic [83:0] tmp1, commit_value;
   logic [4:0]  count;
   logic        commit_valid;

   always #5 clk = ~clk;

   set_time_editor dut (
      .clk          (clk),
      .reset        (reset),
      .mode         (mode),
      .btn_left     (btn_left),
      .btn_right    (btn_right),
      .btn_up       (btn_up),
      .btn_down     (btn_down),
      .load_value   (load_value),
      .commit_ready (commit_ready),
      .tmp1         (tmp1),
      .count        (count),
      .commit_valid (commit_valid),
      .commit_value (commit_value)
   );

   typedef struct {
      logic [3:0] btn;
      logic [4:0] count;
      logic [4:0] nib_idx;
      logic [3:0] nib;
   } vec_t;

   typedef struct {
      string       name;
      logic [4:0]  count;
      logic        valid;
      logic        chk_buf;
      logic [83:0] buf_v;
      logic        chk_nib;
      logic [4:0]  nib_idx;
      logic [3:0]  nib;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   tests_run = 0;
   int   tests_failed = 0;

   task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input string name, input logic [4:0] c, input logic v,
                               input logic cb, input logic [83:0] b,
                               input logic cn, input logic [4:0] ni, input logic [3:0] n);
      exp_t e;
      e.name = name; e.count = c; e.valid = v; e.chk_buf = cb; e.buf_v = b;
      e.chk_nib = cn; e.nib_idx = ni; e.nib = n;
      return e;
   endfunction

   function automatic void add_vec(input logic [3:0] b, input logic [4:0] c,
                                   input logic [4:0] ni, input logic [3:0] n);
      vec_t v;
      v.btn = b; v.count = c; v.nib_idx = ni; v.nib = n;
      vecs.push_back(v);
   endfunction

   // Drive one cycle of inputs on the falling edge, queue the expectation, then
   // compare 1 time unit after the following rising edge.
   task automatic step(input logic [3:0] m, input logic [3:0] b, input logic rdy,
                       input logic rst, input exp_t e);
      exp_t got;
      logic [6:0] lsb;
      @(negedge clk);
      mode = m;
      {btn_up, btn_down, btn_left, btn_right} = b;
      commit_ready = rdy;
      reset = rst;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check({got.name, " count"}, 84'(count), 84'(got.count));
      check({got.name, " commit_valid"}, 84'(commit_valid), 84'(got.valid));
      if (got.chk_buf) begin
         check({got.name, " tmp1"}, tmp1, got.buf_v);
         if (got.valid)
            check({got.name, " commit_value"}, commit_value, got.buf_v);
      end
      if (got.chk_nib) begin
         lsb = {got.nib_idx, 2'b00};
         check($sformatf("%s nib%0d", got.name, got.nib_idx), 84'(tmp1[lsb +: 4]), 84'(got.nib));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Cursor/digit table, applied in EDIT with mode held at SET_MODE.
      add_vec(B_R, 19, 19, 4'h0);  add_vec(B_R, 18, 18, 4'h2);
      add_vec(B_R, 17, 17, 4'h4);  add_vec(B_R, 15, 16, 4'hF);
      add_vec(B_U, 15, 15, 4'h0);  add_vec(B_D, 15, 15, 4'h1);
      add_vec(B_U, 15, 14, 4'h2);  add_vec(B_D, 15, 15, 4'h1);
      add_vec(B_L, 17, 16, 4'hF);  add_vec(B_L, 18, 18, 4'h2);
      add_vec(B_L, 19, 19, 4'h0);  add_vec(B_L, 20, 20, 4'h2);
      add_vec(B_L, 20, 20, 4'h2);  add_vec(B_U, 20, 20, 4'h3);
      add_vec(B_D | B_L, 20, 20, 4'h2);
      add_vec(B_R, 19, 19, 4'h0);  add_vec(B_R, 18, 18, 4'h2);
      add_vec(B_R, 17, 17, 4'h4);  add_vec(B_R, 15, 15, 4'h1);
      add_vec(B_R, 14, 14, 4'h2);  add_vec(B_R, 12, 12, 4'h3);
      add_vec(B_R, 11, 11, 4'h1);  add_vec(B_R,  9,  9, 4'h2);
      add_vec(B_R,  8,  8, 4'h3);
      add_vec(B_U | B_L, 8, 8, 4'h4);
      add_vec(B_D | B_R, 8, 8, 4'h3);
      add_vec(B_R,  6,  6, 4'h5);  add_vec(B_R,  5,  5, 4'h9);
      add_vec(B_R,  3,  3, 4'h5);  add_vec(B_R,  2,  2, 4'h9);
      add_vec(B_R,  0,  0, 4'h6);  add_vec(B_R,  0,  0, 4'h6);
      add_vec(B_U,  0,  0, 4'h0);  add_vec(B_D,  0,  0, 4'h6);
      add_vec(B_U,  0,  1, 4'hF);  add_vec(B_NONE, 0, 0, 4'h0);

      // Reset state.
      step(4'd0, B_NONE, 1'b0, 1'b1, mk("reset0", 20, 1'b0, 1'b1, RST_BUF, 1'b0, 0, 0));
      step(4'd0, B_NONE, 1'b0, 1'b1, mk("reset1", 20, 1'b0, 1'b1, RST_BUF, 1'b0, 0, 0));

      // IDLE tracks load_value with separators forced and digits clamped.
      load_value = RAW_TIME;
      step(4'd0, B_NONE, 1'b0, 1'b0, mk("idle_track", 20, 1'b0, 1'b1, SAN_TIME, 1'b0, 0, 0));

      // Enter edit: IDLE -> LOAD -> EDIT.
      step(SET_MODE, B_NONE, 1'b0, 1'b0, mk("to_load", 20, 1'b0, 1'b0, '0, 1'b0, 0, 0));
      step(SET_MODE, B_NONE, 1'b0, 1'b0, mk("to_edit", 20, 1'b0, 1'b0, '0, 1'b0, 0, 0));
      check("load year", 84'(tmp1[83:68]), 84'(16'h2024));

      foreach (vecs[k])
         step(SET_MODE, vecs[k].btn, 1'b0, 1'b0,
              mk($sformatf("vec%0d", k), vecs[k].count, 1'b0, 1'b0, '0, 1'b1,
                 vecs[k].nib_idx, vecs[k].nib));
      check("edited buffer", tmp1, EDIT_TIME);

      // Commit: buttons in the mode-exit cycle are ignored; hold until ready.
      step(4'd0, B_U, 1'b0, 1'b0, mk("commit_c1", 0, 1'b1, 1'b1, EDIT_TIME, 1'b0, 0, 0));
      step(4'd0, B_NONE, 1'b0, 1'b0, mk("commit_c2", 0, 1'b1, 1'b1, EDIT_TIME, 1'b0, 0, 0));
      step(SET_MODE, B_NONE, 1'b0, 1'b0, mk("commit_c3", 0, 1'b1, 1'b1, EDIT_TIME, 1'b0, 0, 0));
      step(SET_MODE, B_NONE, 1'b1, 1'b0, mk("commit_done", 0, 1'b0, 1'b0, '0, 1'b0, 0, 0));
      step(SET_MODE, B_NONE, 1'b0, 1'b0, mk("reenter_load", 20, 1'b0, 1'b1, SAN_TIME, 1'b0, 0, 0));
      step(SET_MODE, B_NONE, 1'b0, 1'b0, mk("reenter_edit", 20, 1'b0, 1'b1, SAN_TIME, 1'b0, 0, 0));

      // Edit again, then reset mid-edit: everything returns to idle, no commit.
      step(SET_MODE, B_R, 1'b0, 1'b0, mk("edit2_r", 19, 1'b0, 1'b1, SAN_TIME, 1'b0, 0, 0));
      step(SET_MODE, B_U, 1'b0, 1'b0, mk("edit2_u", 19, 1'b0, 1'b0, '0, 1'b1, 19, 4'h1));
      step(4'd0, B_NONE, 1'b0, 1'b1, mk("mid_reset", 20, 1'b0, 1'b1, RST_BUF, 1'b0, 0, 0));
      for (int i = 0; i < 4; i++)
         step(4'd0, B_NONE, 1'b0, 1'b0,
              mk($sformatf("post_reset%0d", i), 20, 1'b0, 1'b1, SAN_TIME, 1'b0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
